// File: rtl/mux16_rr_arbiter_if.sv
// mux16_rr_arbiter_if: request/grant bus between the requesters and the mux select arbiter
// req: request vector (bit i = requester i wants the mux)
// grant: one-hot grant, all-zero when idle
// sel: index of the current owner, drives the 16:1 mux select
// busy: high while any grant is asserted
// hold_cnt: cycles the current owner has held the grant, 0-based
interface mux16_rr_arbiter_if;
    logic [15:0] req;
    logic [15:0] grant;
    logic [3:0]  sel;
    logic        busy;
    logic [7:0]  hold_cnt;
    modport master (output req, input grant, sel, busy, hold_cnt);
    modport slave (input req, output grant, sel, busy, hold_cnt);
endinterface

// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter: round-robin owner selection for a shared 16:1 datapath mux, all outputs registered
// clk: rising-edge clock; reset_n: asynchronous active-low reset
// bus: slave side of mux16_rr_arbiter_if (req in; grant, sel, busy, hold_cnt out)
// MAX_HOLD: consecutive cycles an owner may keep the mux while others wait (1..255)
module mux16_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input logic               clk,
    input logic               reset_n,
    mux16_rr_arbiter_if.slave bus
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t      state_q, state_d;
    logic [15:0] grant_q, grant_d;
    logic [3:0]  sel_q, sel_d, ptr_q, ptr_d;
    logic        busy_q, busy_d;
    logic [7:0]  hold_q, hold_d;
    logic [15:0] others;
    logic        at_lim, handover, search;
    logic [4:0]  pick_idle, pick_next, pick;
    // {found, index} of the first set bit scanning circularly upward from s
    function automatic logic [4:0] rr_pick(input logic [15:0] r, input logic [3:0] s);
        logic [15:0] d;
        rr_pick = '0;
        d = 16'({r, r} >> s);
        for (int k = 15; k >= 0; k--)
            if (d[k]) rr_pick = {1'b1, s + 4'(k)};
    endfunction
    // Masking the owner covers both cases: on a drop its bit is already clear,
    // on forced rotation it must be excluded so it cannot win twice in a row.
    assign others    = bus.req & ~(16'd1 << sel_q);
    assign at_lim    = hold_q == 8'(MAX_HOLD - 1);
    assign pick_idle = rr_pick(bus.req, ptr_q);
    assign pick_next = rr_pick(others, sel_q + 4'd1);
    always_comb begin
        handover = state_q == GRANT && (!bus.req[sel_q] || (at_lim && |others));
        search   = state_q == IDLE || handover;
        pick     = handover ? pick_next : pick_idle;
        state_d  = search ? (pick[4] ? GRANT : IDLE) : state_q;
        grant_d  = search ? (pick[4] ? 16'd1 << pick[3:0] : '0) : grant_q;
        sel_d    = (search && pick[4]) ? pick[3:0] : sel_q;
        busy_d   = search ? pick[4] : busy_q;
        hold_d   = search ? '0 : (at_lim ? hold_q : hold_q + 8'd1);
        ptr_d    = handover ? sel_q + 4'd1 : ptr_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            hold_q  <= hold_d;
        end
    end
    assign bus.grant    = grant_q;
    assign bus.sel      = sel_q;
    assign bus.busy     = busy_q;
    assign bus.hold_cnt = hold_q;
endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// tb_mux16_rr_arbiter: four arbiters (MAX_HOLD 8,4,2,3) on one request vector, checked against a behavioural model
module tb_mux16_rr_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] req = '0;
    logic [15:0] gnt [4];
    logic [3:0]  sl [4];
    logic        bsy [4];
    logic [7:0]  hco [4];
    int errors = 0, checks = 0;
    int mh [4] = '{8, 4, 2, 3};
    int own [4], hc [4], ptr [4], msel [4], wmax [4];
    int wt [4][16];
    always #5 clk = ~clk;
    for (genvar g = 0; g < 4; g++) begin : u
        mux16_rr_arbiter_if b();
        mux16_rr_arbiter #(.MAX_HOLD(g == 0 ? 8 : g == 1 ? 4 : g == 2 ? 2 : 3)) dut (
            .clk(clk), .reset_n(reset_n), .bus(b));
        assign b.req  = req;
        assign gnt[g] = b.grant;
        assign sl[g]  = b.sel;
        assign bsy[g] = b.busy;
        assign hco[g] = b.hold_cnt;
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic int search(input logic [15:0] r, input int start);
        int w = -1;
        for (int k = 15; k >= 0; k--)
            if (r[(start + k) % 16]) w = (start + k) % 16;
        return w;
    endfunction
    task automatic model_reset();
        for (int m = 0; m < 4; m++) begin
            own[m] = -1; hc[m] = 0; ptr[m] = 0; msel[m] = 0;
            for (int i = 0; i < 16; i++) wt[m][i] = 0;
        end
    endtask
    task automatic model_step(input logic [15:0] r);
        logic [15:0] rest;
        for (int m = 0; m < 4; m++) begin
            if (own[m] < 0) begin
                own[m] = search(r, ptr[m]);
                hc[m] = 0;
            end else begin
                rest = r & ~(16'd1 << own[m]);
                if (!r[own[m]] || (hc[m] == mh[m] - 1 && rest != 0)) begin
                    ptr[m] = (own[m] + 1) % 16;
                    own[m] = search(rest, ptr[m]);
                    hc[m] = 0;
                end else if (hc[m] < mh[m] - 1) hc[m]++;
            end
            if (own[m] >= 0) msel[m] = own[m];
        end
    endtask
    task automatic check_all();
        for (int m = 0; m < 4; m++) begin
            chk($sformatf("d%0d.grant", m), gnt[m], own[m] >= 0 ? 16'd1 << own[m] : 16'd0);
            chk($sformatf("d%0d.sel", m), sl[m], msel[m]);
            chk($sformatf("d%0d.busy", m), bsy[m], own[m] >= 0);
            chk($sformatf("d%0d.hold_cnt", m), hco[m], hc[m]);
            chk($sformatf("d%0d.onehot", m), $onehot0(gnt[m]), 1);
            if (bsy[m]) chk($sformatf("d%0d.selgnt", m), gnt[m], 16'd1 << sl[m]);
            for (int i = 0; i < 16; i++) begin
                wt[m][i] = (req[i] && !gnt[m][i]) ? wt[m][i] + 1 : 0;
                if (wt[m][i] > wmax[m]) wmax[m] = wt[m][i];
            end
        end
    endtask
    task automatic step(input logic [15:0] r);
        req = r;
        @(posedge clk);
        #1;
        model_step(r);
        check_all();
    endtask
    task automatic do_reset();
        #2 reset_n = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge clk) reset_n = 1'b1;
    endtask
    initial begin
        logic [15:0] r;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all();
        @(negedge clk) reset_n = 1'b1;
        // asynchronous reset in the middle of owner 5's grant
        step(16'h0020);
        chk("mid_owner5", gnt[0], 16'h0020);
        do_reset();
        chk("rst_grant", gnt[0], 16'h0000);
        chk("rst_sel", sl[0], 0);
        chk("rst_busy", bsy[0], 0);
        step(16'h0001);
        chk("rst_rel_grant", gnt[0], 16'h0001);
        // lone requester keeps the mux, hold_cnt saturates
        for (int c = 0; c < 20; c++) step(16'h0100);
        chk("single_grant", gnt[0], 16'h0100);
        chk("single_hold", hco[0], 7);
        step(16'h0000);
        chk("single_drop_grant", gnt[0], 16'h0000);
        chk("single_drop_busy", bsy[0], 0);
        // all requesting, MAX_HOLD=4: each owner for exactly four cycles
        do_reset();
        for (int c = 0; c < 68; c++) begin
            step(16'hFFFF);
            chk("rr_sel", sl[1], (c / 4) % 16);
        end
        // owner 3 drops while 0 and 2 request: scan from 4 wraps to 0
        do_reset();
        step(16'h0008);
        step(16'h0005);
        chk("ptr_grant", gnt[0], 16'h0001);
        chk("ptr_busy", bsy[0], 1);
        // forced rotation between 15 and 0 with MAX_HOLD=2
        do_reset();
        step(16'h8000);
        chk("rot_first", gnt[2], 16'h8000);
        step(16'h8001);
        step(16'h8001);
        chk("rot_to0", gnt[2], 16'h0001);
        step(16'h8001);
        step(16'h8001);
        chk("rot_to15", gnt[2], 16'h8000);
        // random stress with persistent, slowly toggling requests
        do_reset();
        for (int m = 0; m < 4; m++) wmax[m] = 0;
        r = '0;
        for (int c = 0; c < 10000; c++) begin
            r ^= 16'($urandom & $urandom & $urandom);
            step(r);
        end
        for (int m = 0; m < 4; m++)
            chk($sformatf("d%0d.starve", m), wmax[m] <= 15 * mh[m] + 1, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
